// File: rtl/memory_pkg.sv
// Shared types and constants for the byte-enabled, self-clearing memory block.
package memory_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MAX_RD_LATENCY = 4;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line carrying {valid, err, data} behind the array register.
module mem_rd_pipe
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign valid_o = valid_i;
      assign err_o   = err_i;
      assign data_o  = data_i;
    end else begin : g_pipe
      logic [STAGES-1:0]     valid_q;
      logic [STAGES-1:0]     err_q;
      logic [DATA_WIDTH-1:0] data_q [STAGES];

      // Shift stages; data only moves with a valid beat so the tail holds the last read
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= '0;
          err_q   <= '0;
          for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
          end
        end else begin
          valid_q[0] <= valid_i;
          err_q[0]   <= err_i;
          if (valid_i) begin
            data_q[0] <= data_i;
          end
          for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            if (valid_q[i-1]) begin
              data_q[i] <= data_q[i-1];
            end
          end
        end
      end

      assign valid_o = valid_q[STAGES-1];
      assign err_o   = err_q[STAGES-1];
      assign data_o  = data_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/memory_be_init.sv
// Single-port memory with byte strobes, pipelined reads, range checking and a
// post-reset clear sweep that writes INIT_VALUE to every word.
module memory_be_init
  import memory_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    STRB_WIDTH = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  s1_valid_q, s1_err_q, wr_err_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  in_range_s, accept_s, rd_acc_s, wr_acc_s, wr_bad_s, sweep_we_s;
  logic [DATA_WIDTH-1:0] rd_word_s, wmerge_s;
  logic                  pipe_valid_s, pipe_err_s;
  logic [DATA_WIDTH-1:0] pipe_data_s;

  // A full power-of-two array cannot be addressed out of range
  generate
    if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
      assign in_range_s = 1'b1;
    end else begin : g_part_range
      assign in_range_s = ({1'b0, addr_i} < DEPTH_EXT);
    end
  endgenerate

  assign ready_o     = (state_q == ST_RUN);
  assign init_done_o = (state_q == ST_RUN);
  assign accept_s    = valid_i & ready_o;
  assign rd_acc_s    = accept_s & ~wr_rd_en_i;
  assign wr_acc_s    = accept_s & wr_rd_en_i & (|wstrb_i) & in_range_s;
  assign wr_bad_s    = accept_s & wr_rd_en_i & (|wstrb_i) & ~in_range_s;
  assign sweep_we_s  = ~rst_i & (state_q == ST_INIT);
  assign rd_word_s   = mem_q[addr_i];

  // Sweep counter and INIT/RUN sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte-lane merge of the incoming word over the stored word
  always_comb begin
    wmerge_s = rd_word_s;
    for (int n = 0; n < STRB_WIDTH; n++) begin
      if (wstrb_i[n]) begin
        wmerge_s[n*BYTE_W +: BYTE_W] = wdata_i[n*BYTE_W +: BYTE_W];
      end else begin
        wmerge_s[n*BYTE_W +: BYTE_W] = rd_word_s[n*BYTE_W +: BYTE_W];
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= rd_acc_s;
      s1_err_q   <= rd_acc_s & ~in_range_s;
      wr_err_q   <= wr_bad_s;
      if (rd_acc_s) begin
        s1_data_q <= in_range_s ? rd_word_s : '0;
      end
    end
  end

  // Storage array: the sweep has priority, it only runs while no request can be accepted
  always_ff @(posedge clk_i) begin
    if (sweep_we_s) begin
      mem_q[cnt_q] <= INIT_VALUE;
    end else if (wr_acc_s) begin
      mem_q[addr_i] <= wmerge_s;
    end
  end

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (s1_valid_q),
    .err_i   (s1_err_q),
    .data_i  (s1_data_q),
    .valid_o (pipe_valid_s),
    .err_o   (pipe_err_s),
    .data_o  (pipe_data_s)
  );

  assign rvalid_o = pipe_valid_s;
  assign rdata_o  = pipe_data_s;
  assign err_o    = (pipe_valid_s & pipe_err_s) | wr_err_q;

endmodule
